memoria_carregador: RTL and testbench
=====================================

MEMORIA_CARREGADOR -- requirements
Module: memoria_carregador

Interface
REQ-001 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- load_valid  input  1  loader byte present on load_data.
- load_data  input  8  program byte to store.
- load_last  input  1  marks the final program byte; qualified by load_valid.
- load_ready  output  1  block accepts a loader byte this cycle.
- address  input  8  processor memory address.
- to_memory  input  8  processor write data.
- mem_write  input  1  processor write strobe.
- from_memory  output  8  read data returned to the processor.
- done  input  1  processor halt indication.
- cpu_reset_n  output  1  active-low reset driven to the processor.
- halted  output  1  block is in HALT.

REQ-002 Clock and reset: one clock; reset is asynchronous and active-low, ports named clock and reset.

REQ-003 There SHALL be no parameters: 256 x 8 storage and an 8-bit address.

Function
REQ-004 FSM states SHALL be LOAD, FILL, RUN and HALT, held in registers.
REQ-005 In LOAD, load_ready SHALL be 1 and cpu_reset_n 0.
REQ-006 A transfer SHALL occur when load_valid and load_ready are both 1 at a clock edge; load_data is written at load_ptr, then load_ptr increments by 1.
REQ-007 If the accepted byte has load_last=1 and load_ptr<255, the next state SHALL be FILL.
REQ-008 If the accepted byte is at load_ptr=255, regardless of load_last, the next state SHALL be RUN and load_ptr SHALL wrap to 0.
REQ-009 In FILL, 8'h00 SHALL be written at load_ptr each cycle with load_ptr incrementing, and load_ready SHALL be 0.
REQ-010 The write at load_ptr=255 in FILL SHALL be the last one, followed by RUN.
REQ-011 In RUN, cpu_reset_n SHALL be 1 and load_ready 0.
REQ-012 In RUN, from_memory SHALL be registered: mem[address] sampled at edge N appears after edge N (1-cycle latency).
REQ-013 In RUN, when mem_write=1 at an edge, to_memory SHALL be written to mem[address].
REQ-014 A same-cycle read of a written address SHALL return the old data (read-before-write).
REQ-015 In RUN, done=1 at an edge SHALL move the FSM to HALT.
REQ-016 In HALT: halted=1, cpu_reset_n=1, mem_write ignored, from_memory continues to follow address, and load_ready=0.
REQ-017 HALT SHALL be exited only by reset.
REQ-018 The block SHALL ignore:
- load_valid and load_last outside LOAD;
- mem_write outside RUN;
- done outside RUN.
REQ-019 In LOAD and FILL, from_memory SHALL hold 8'h00.
REQ-020 A load_last with load_valid=0 SHALL have no effect.

Reset
REQ-021 While reset=0, the block SHALL drive:
- state=LOAD
- load_ptr=0
- from_memory=8'h00
- load_ready=0
- cpu_reset_n=0
- halted=0
REQ-022 load_ready SHALL rise in the first cycle after reset deasserts.
REQ-023 Storage contents SHALL NOT be cleared by reset; FILL guarantees defined contents before RUN.
REQ-024 Reset asserted mid-LOAD, mid-FILL or in RUN SHALL abort immediately, and a following load SHALL restart at address 0.
REQ-025 cpu_reset_n SHALL be glitch-free: it is driven from a register, not from combinational FSM decode.

Verification
REQ-026 Load 3 bytes A1,B2,C3 with load_last on C3 -> FILL for 253 cycles, then RUN, cpu_reset_n=1; reads of addresses 0,1,2,3,255 return A1,B2,C3,00,00 one cycle after the address is applied.
REQ-027 Load 256 bytes (value=index), load_last never asserted -> direct to RUN after byte 255, no FILL; address 8'hFF reads FF.
REQ-028 In RUN, write 5A to address 10 with a same-cycle read of 10 -> from_memory shows the old value next cycle and 5A on the following read.
REQ-029 In RUN, pulse done -> halted=1 next cycle; a subsequent mem_write of 77 to address 10 leaves address 10 reading 5A; load_valid is ignored.
REQ-030 Assert reset after 5 loaded bytes, reload 2 bytes with load_last -> address 0,1 hold the new bytes, 2..255 read 00, and load_ready stays 0 during reset.
REQ-031 Hold load_valid=0 for 20 cycles in LOAD, with load_last toggling -> no pointer advance and state remains LOAD.

Source files
------------

// File: rtl/memoria_carregador.sv
// Program loader and 256x8 processor memory: streams a program in,
// zero-fills the rest, then serves the processor until it halts.
//
// Ports:
//   clock, reset        : rising-edge clock, async active-low reset
//   load_valid/data/last: loader byte stream; load_ready accepts it
//   address, to_memory  : processor address and write data
//   mem_write           : processor write strobe (honoured in RUN only)
//   from_memory         : registered read data (1-cycle latency)
//   done                : processor halt request
//   cpu_reset_n         : registered active-low processor reset
//   halted              : block has reached HALT
module memoria_carregador (
   input  logic       clock,
   input  logic       reset,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   input  logic       load_last,
   output logic       load_ready,
   input  logic [7:0] address,
   input  logic [7:0] to_memory,
   input  logic       mem_write,
   output logic [7:0] from_memory,
   input  logic       done,
   output logic       cpu_reset_n,
   output logic       halted
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] load_ptr;
   logic [7:0] next_ptr;
   logic [7:0] mem [256];

   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       xfer;

   // Gated by reset so the handshake is low while reset is held and
   // opens as soon as it is released.
   assign load_ready = (state == LOAD) && reset;
   assign xfer       = load_valid && load_ready;

   always_comb begin
      next_state = state;
      next_ptr   = load_ptr;
      wr_en      = 1'b0;
      wr_addr    = load_ptr;
      wr_data    = 8'h00;
      unique case (state)
         LOAD: begin
            if (xfer) begin
               wr_en    = 1'b1;
               wr_data  = load_data;
               next_ptr = load_ptr + 8'd1;
               if (load_ptr == 8'hFF) begin
                  next_state = RUN;
               end else if (load_last) begin
                  next_state = FILL;
               end
            end
         end
         FILL: begin
            wr_en    = 1'b1;
            next_ptr = load_ptr + 8'd1;
            if (load_ptr == 8'hFF) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (mem_write) begin
               wr_en   = 1'b1;
               wr_addr = address;
               wr_data = to_memory;
            end
            if (done) begin
               next_state = HALT;
            end
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = LOAD;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= LOAD;
         load_ptr    <= 8'h00;
         from_memory <= 8'h00;
         cpu_reset_n <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state    <= next_state;
         load_ptr <= next_ptr;
         // Outputs follow the next state so they change cleanly off a flop.
         cpu_reset_n <= (next_state == RUN) || (next_state == HALT);
         halted      <= (next_state == HALT);
         if ((state == RUN) || (state == HALT)) begin
            from_memory <= mem[address];
         end else begin
            from_memory <= 8'h00;
         end
      end
   end

   // Storage is deliberately not reset; FILL defines every location.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_memoria_carregador.sv
// Directed bench for memoria_carregador: load/fill/run/halt flows,
// read latency, read-before-write and reset abort.
module tb_memoria_carregador;

   logic       clock;
   logic       reset;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic [7:0] address;
   logic [7:0] to_memory;
   logic       mem_write;
   logic [7:0] from_memory;
   logic       done;
   logic       cpu_reset_n;
   logic       halted;

   int checks;
   int passed;

   memoria_carregador dut (
      .clock       (clock),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .address     (address),
      .to_memory   (to_memory),
      .mem_write   (mem_write),
      .from_memory (from_memory),
      .done        (done),
      .cpu_reset_n (cpu_reset_n),
      .halted      (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic load_byte(input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      @(negedge clock);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic rd(input string tag,
                     input logic [7:0] a,
                     input logic [7:0] exp);
      address = a;
      @(negedge clock);
      check(tag, from_memory, exp);
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   initial begin
      checks     = 0;
      passed     = 0;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      address    = 8'h00;
      to_memory  = 8'h00;
      mem_write  = 1'b0;
      done       = 1'b0;

      wait_cyc(2);
      check("rst_load_ready", load_ready, 8'd0);
      check("rst_cpu_reset_n", cpu_reset_n, 8'd0);
      check("rst_halted", halted, 8'd0);
      check("rst_from_memory", from_memory, 8'h00);

      reset = 1'b1;
      #1;
      check("ready_after_rst", load_ready, 8'd1);
      @(negedge clock);

      // Idle LOAD with load_last toggling and no valid.
      for (int i = 0; i < 20; i++) begin
         load_last = i[0];
         @(negedge clock);
      end
      load_last = 1'b0;
      check("idle_ready", load_ready, 8'd1);
      check("idle_cpu_rst", cpu_reset_n, 8'd0);

      // Short program then zero fill.
      load_byte(8'hA1, 1'b0);
      load_byte(8'hB2, 1'b0);
      load_byte(8'hC3, 1'b1);
      check("fill_ready", load_ready, 8'd0);
      check("fill_from_mem", from_memory, 8'h00);
      wait_cyc(252);
      check("fill_252_cpu_rst", cpu_reset_n, 8'd0);
      wait_cyc(1);
      check("run_cpu_rst", cpu_reset_n, 8'd1);
      check("run_ready", load_ready, 8'd0);
      rd("rd0", 8'd0, 8'hA1);
      rd("rd1", 8'd1, 8'hB2);
      rd("rd2", 8'd2, 8'hC3);
      rd("rd3", 8'd3, 8'h00);
      rd("rd255", 8'd255, 8'h00);

      // Read-before-write at address 10.
      address   = 8'd10;
      to_memory = 8'h5A;
      mem_write = 1'b1;
      @(negedge clock);
      mem_write = 1'b0;
      check("rbw_old", from_memory, 8'h00);
      @(negedge clock);
      check("rbw_new", from_memory, 8'h5A);

      // Halt, then writes and loader bytes are ignored.
      done = 1'b1;
      @(negedge clock);
      done = 1'b0;
      check("halted", halted, 8'd1);
      check("halt_cpu_rst", cpu_reset_n, 8'd1);
      address    = 8'd10;
      to_memory  = 8'h77;
      mem_write  = 1'b1;
      load_valid = 1'b1;
      load_data  = 8'h33;
      @(negedge clock);
      mem_write  = 1'b0;
      load_valid = 1'b0;
      check("halt_rd10_a", from_memory, 8'h5A);
      @(negedge clock);
      check("halt_rd10_b", from_memory, 8'h5A);
      check("halt_ready", load_ready, 8'd0);
      rd("halt_rd0", 8'd0, 8'hA1);
      check("halt_stays", halted, 8'd1);

      // Reset from HALT, partial load, abort mid-LOAD, reload.
      reset = 1'b0;
      #1;
      check("rst2_halted", halted, 8'd0);
      check("rst2_cpu_rst", cpu_reset_n, 8'd0);
      check("rst2_from_mem", from_memory, 8'h00);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         load_byte(8'h11 + 8'(i), 1'b0);
      end
      reset = 1'b0;
      #1;
      check("rst3_ready", load_ready, 8'd0);
      load_valid = 1'b1;
      load_data  = 8'hEE;
      @(negedge clock);
      check("rst3_ready_hold", load_ready, 8'd0);
      load_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      load_byte(8'h21, 1'b0);
      load_byte(8'h22, 1'b1);
      wait_cyc(253);
      check("fill2_cpu_rst_lo", cpu_reset_n, 8'd0);
      wait_cyc(1);
      check("fill2_cpu_rst_hi", cpu_reset_n, 8'd1);
      rd("re_rd0", 8'd0, 8'h21);
      rd("re_rd1", 8'd1, 8'h22);
      rd("re_rd2", 8'd2, 8'h00);
      rd("re_rd4", 8'd4, 8'h00);
      rd("re_rd10", 8'd10, 8'h00);
      rd("re_rd255", 8'd255, 8'h00);

      // Full 256-byte load, no load_last, no FILL.
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 255; i++) begin
         load_byte(8'(i), 1'b0);
      end
      check("full_ready_254", load_ready, 8'd1);
      check("full_cpu_rst_lo", cpu_reset_n, 8'd0);
      load_byte(8'hFF, 1'b0);
      check("full_cpu_rst_hi", cpu_reset_n, 8'd1);
      check("full_ready_run", load_ready, 8'd0);
      rd("full_rdFF", 8'hFF, 8'hFF);
      rd("full_rd80", 8'h80, 8'h80);
      rd("full_rd03", 8'h03, 8'h03);
      rd("full_rd00", 8'h00, 8'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
